// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer.
//   btn_state_e : per-channel debounce state encoding
//   DEF_*       : default timing values (clk_i cycles)
//   clog2()     : ceiling log2 for sizing counters from parameters
package btn_pkg;

   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } btn_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 10000;
   localparam int DEF_REPEAT_DELAY    = 500000;
   localparam int DEF_REPEAT_PERIOD   = 100000;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res = res + 1;
      return res;
   endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounced button channel: 2-flop synchroniser, stability FSM,
// registered level plus single-cycle press/release pulses.
// Optional auto-repeat of the press pulse while held, enabled by defining
// BUTTON_DEBOUNCER_AUTOREPEAT_EN.
// Ports:
//   clk_i     in  system clock
//   rst_ni    in  asynchronous active-low reset
//   btn_i     in  raw asynchronous button, active-high
//   level_o   out debounced level
//   press_o   out 1-cycle pulse on debounced rise (and auto-repeat)
//   release_o out 1-cycle pulse on debounced fall
//
// state  | meaning
// S_LOW  | debounced low, synchronised input low
// S_RISE | debounced low, input high, counting stable cycles
// S_HIGH | debounced high, synchronised input high
// S_FALL | debounced high, input low, counting stable cycles
module btn_debounce_chan
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   // Stability timer is a down-counter: loaded with the number of further
   // stable cycles still needed, terminal count at 1.
   localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("btn_debounce_chan: DEBOUNCE_CYCLES must be at least 2");
   end

   logic [1:0]       sync_q, sync_d;
   logic             btn_s;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             fsm_press;

   always_comb sync_d = {sync_q[0], btn_i};
   assign btn_s = sync_q[1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      fsm_press = 1'b0;
      release_d = 1'b0;
      case (state_q)
         S_LOW: begin
            if (btn_s) begin
               state_d = S_RISE;
               cnt_d   = CNT_LOAD;
            end
         end
         S_RISE: begin
            if (!btn_s) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TC) begin
               state_d   = S_HIGH;
               cnt_d     = '0;
               level_d   = 1'b1;
               fsm_press = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_TC;
            end
         end
         S_HIGH: begin
            if (!btn_s) begin
               state_d = S_FALL;
               cnt_d   = CNT_LOAD;
            end
         end
         S_FALL: begin
            if (btn_s) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TC) begin
               state_d   = S_LOW;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_TC;
            end
         end
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] RPT_DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_bad_repeat
      $error("btn_debounce_chan: REPEAT_DELAY must be >= 1 and REPEAT_PERIOD >= 2");
   end

   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             rpt_pulse;

   // Hold timer only advances on cycles that keep the channel in S_HIGH;
   // any (re)entry into S_HIGH restarts the initial delay.
   always_comb begin
      rpt_d     = '0;
      rpt_pulse = 1'b0;
      if (state_q == S_HIGH && btn_s) begin
         if (rpt_q == '0) begin
            rpt_pulse = 1'b1;
            rpt_d     = RPT_PERIOD_LOAD;
         end else begin
            rpt_d = rpt_q - RPT_W'(1);
         end
      end else if (state_d == S_HIGH) begin
         rpt_d = RPT_DELAY_LOAD;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rpt_q <= '0;
      else         rpt_q <= rpt_d;
   end

   assign press_d = fsm_press | rpt_pulse;
`else
   // Repeat timing is unused in this build; still reject nonsense values.
   if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_bad_repeat
      $error("btn_debounce_chan: REPEAT_DELAY/REPEAT_PERIOD must not be negative");
   end

   assign press_d = fsm_press;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q    <= '0;
         state_q   <= S_LOW;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: NUM_BTN independent channels, each
// producing a clean level and press/release pulses for the up/down counter.
// Optional auto-repeat of press pulses while held: define
// BUTTON_DEBOUNCER_AUTOREPEAT_EN.
// Ports:
//   clk_i         in  system clock
//   rst_ni        in  asynchronous active-low reset
//   btn_i         in  [NUM_BTN] raw asynchronous buttons, active-high
//   btn_level_o   out [NUM_BTN] debounced levels
//   btn_press_o   out [NUM_BTN] 1-cycle press pulses (and auto-repeat)
//   btn_release_o out [NUM_BTN] 1-cycle release pulses
module button_debouncer
   import btn_pkg::*;
#(
   parameter int NUM_BTN         = 2,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_BTN-1:0] btn_i,
   output logic [NUM_BTN-1:0] btn_level_o,
   output logic [NUM_BTN-1:0] btn_press_o,
   output logic [NUM_BTN-1:0] btn_release_o
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .btn_i     (btn_i[i]),
         .level_o   (btn_level_o[i]),
         .press_o   (btn_press_o[i]),
         .release_o (btn_release_o[i])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

   localparam int NB = 2;
   localparam int DC = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [NB-1:0] btn_i = '0;
   logic [NB-1:0] btn_level_o, btn_press_o, btn_release_o;

   always #5 clk_i = ~clk_i;

   button_debouncer #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DC),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .btn_i         (btn_i),
      .btn_level_o   (btn_level_o),
      .btn_press_o   (btn_press_o),
      .btn_release_o (btn_release_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: btn_s is the input two cycles back; the level flips
   // once the synchronised input has disagreed with it for DC consecutive
   // cycles, and the output seen in the following cycle reflects the flip.
   logic [NB-1:0] m_d1, m_d2, m_level, m_press, m_release;
   int            m_run [NB];
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   int            m_streak [NB];
`endif

   task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_release = '0;
      for (int ch = 0; ch < NB; ch++) begin
         m_run[ch] = 0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
         m_streak[ch] = 0;
`endif
      end
   endfunction

   // Advance the model by one cycle with input v; m_* then hold the outputs
   // expected in the next cycle.
   function automatic void model_step(input logic [NB-1:0] v);
      for (int ch = 0; ch < NB; ch++) begin
         logic bs;
         logic high_now;
         bs = m_d2[ch];
         high_now = m_level[ch] && (m_run[ch] == 0);
         m_press[ch] = 1'b0;
         m_release[ch] = 1'b0;
         if (bs != m_level[ch]) m_run[ch]++;
         else                   m_run[ch] = 0;
         if (m_run[ch] == DC) begin
            m_level[ch] = ~m_level[ch];
            m_run[ch] = 0;
            if (m_level[ch]) m_press[ch] = 1'b1;
            else             m_release[ch] = 1'b1;
         end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
         if (high_now && bs) m_streak[ch]++;
         else                m_streak[ch] = 0;
         if (m_streak[ch] >= RD && ((m_streak[ch] - RD) % RP) == 0) m_press[ch] = 1'b1;
`else
         if (high_now && !high_now) m_press[ch] = 1'b1;
`endif
      end
      m_d2 = m_d1;
      m_d1 = v;
   endfunction

   task automatic compare_model();
      check("model_level", btn_level_o, m_level);
      check("model_press", btn_press_o, m_press);
      check("model_release", btn_release_o, m_release);
      check("press_release_exclusive", btn_press_o & btn_release_o, '0);
   endtask

   // Called at a negedge: drive this cycle's input, step to the next cycle.
   task automatic tick(input logic [NB-1:0] v);
      btn_i = v;
      model_step(v);
      @(negedge clk_i);
      compare_model();
   endtask

   task automatic do_reset(input logic [NB-1:0] v);
      btn_i = v;
      rst_ni = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      check("reset_level", btn_level_o, '0);
      check("reset_press", btn_press_o, '0);
      check("reset_release", btn_release_o, '0);
      rst_ni = 1'b1;
   endtask

   typedef struct {
      logic [NB-1:0] btn;
      logic [NB-1:0] level;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
   } vec_t;

   vec_t tbl [14];
   int   press_cycles [$];
   int   exp_cycles [$];
   int   bounce_pat [16];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Clean press of ch0, then release ch0 and press ch1 in one cycle.
      for (int i = 0; i < 5; i++)  tbl[i] = '{btn: 2'b01, level: 2'b00, press: 2'b00, rel: 2'b00};
      tbl[5] = '{btn: 2'b01, level: 2'b01, press: 2'b01, rel: 2'b00};
      tbl[6] = '{btn: 2'b01, level: 2'b01, press: 2'b00, rel: 2'b00};
      for (int i = 7; i < 12; i++) tbl[i] = '{btn: 2'b10, level: 2'b01, press: 2'b00, rel: 2'b00};
      tbl[12] = '{btn: 2'b10, level: 2'b10, press: 2'b10, rel: 2'b01};
      tbl[13] = '{btn: 2'b10, level: 2'b10, press: 2'b00, rel: 2'b00};
      bounce_pat = '{1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

      @(negedge clk_i);

      // Reset with both buttons held, then release: press on both at cycle 6.
      do_reset(2'b11);
      for (int k = 0; k < 8; k++) begin
         tick(2'b11);
         check("rst_exit_press", btn_press_o, (k + 1 == 6) ? 2'b11 : 2'b00);
         check("rst_exit_release", btn_release_o, 2'b00);
      end

      // Table-driven clean press / release / independence.
      do_reset(2'b00);
      for (int i = 0; i < 14; i++) begin
         btn_i = tbl[i].btn;
         model_step(tbl[i].btn);
         @(negedge clk_i);
         check("tbl_level", btn_level_o, tbl[i].level);
         check("tbl_press", btn_press_o, tbl[i].press);
         check("tbl_release", btn_release_o, tbl[i].rel);
      end

      // Bounce rejection: last 0->1 at cycle 7, single press at cycle 13.
      do_reset(2'b00);
      begin
         int n_press;
         n_press = 0;
         for (int i = 0; i < 16; i++) begin
            tick({1'b0, bounce_pat[i] == 1});
            if (btn_press_o[0]) n_press++;
            check_int("bounce_press", int'(btn_press_o[0]), (i + 1 == 13) ? 1 : 0);
            check_int("bounce_level", int'(btn_level_o[0]), (i + 1 >= 13) ? 1 : 0);
         end
         check_int("bounce_press_count", n_press, 1);
      end

      // Async reset in the middle of a rise count, then a fresh latency.
      do_reset(2'b00);
      repeat (5) tick(2'b01);
      #2;
      rst_ni = 1'b0;
      model_reset();
      #1;
      check("mid_reset_level", btn_level_o, '0);
      check("mid_reset_press", btn_press_o, '0);
      repeat (2) @(negedge clk_i);
      check("mid_reset_hold_level", btn_level_o, '0);
      rst_ni = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick(2'b01);
         check("mid_reset_relatency", btn_press_o, (k + 1 == 6) ? 2'b01 : 2'b00);
      end

      // Long hold on ch1 (input high in cycles 0..33).
      do_reset(2'b00);
      press_cycles.delete();
      for (int c = 0; c < 50; c++) begin
         tick((c < 34) ? 2'b10 : 2'b00);
         if (btn_press_o[1]) press_cycles.push_back(c + 1);
      end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
      exp_cycles = '{6, 16, 19, 22, 25, 28, 31, 34};
`else
      exp_cycles = '{6};
`endif
      check_int("hold_press_count", press_cycles.size(), exp_cycles.size());
      for (int i = 0; i < exp_cycles.size(); i++) begin
         check_int("hold_press_cycle", (i < press_cycles.size()) ? press_cycles[i] : -1, exp_cycles[i]);
      end

      // Randomised stimulus against the model, varying bounce density.
      do_reset(2'b00);
      begin
         logic [NB-1:0] v;
         int rate;
         v = '0;
         for (int i = 0; i < 4000; i++) begin
            case (i / 1000)
               0:       rate = 3;
               1:       rate = 8;
               2:       rate = 40;
               default: rate = 6;
            endcase
            for (int ch = 0; ch < NB; ch++) begin
               if ($urandom_range(0, rate - 1) == 0) v[ch] = ~v[ch];
            end
            tick(v);
            if ($urandom_range(0, 799) == 0) begin
               #3;
               rst_ni = 1'b0;
               model_reset();
               @(negedge clk_i);
               check("rand_reset_level", btn_level_o, '0);
               rst_ni = 1'b1;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
